// File: rtl/mem_stage_if.sv
// Byte-serial memory-controller port used by the MEM stage.
// master = mem_stage (issues byte requests), slave = memory controller.
interface mem_stage_if #(parameter int ADDR_W = 32);
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [7:0]        mem_wbyte_o;
  logic [7:0]        mem_rbyte_i;
  logic              mem_ack_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wbyte_o,
    input  mem_rbyte_i, mem_ack_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wbyte_o,
    output mem_rbyte_i, mem_ack_i
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: ALU results pass straight through, loads/stores run byte-serially.
// Optional macro MEM_MISALIGN_CHECK_EN traps misaligned half/word accesses instead of issuing them.
module mem_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [5:0]        stall,
  input  logic              write_i,
  input  logic [4:0]        regw_addr_i,
  input  logic [31:0]       regw_data_i,
  input  logic [3:0]        mem_op_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic              write_o,
  output logic [4:0]        regw_addr_o,
  output logic [31:0]       regw_data_o,
  output logic              stall_req_o,
  output logic              misalign_o,
  mem_stage_if.master       mem_bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_next;
  logic [1:0]  k, k_next;
  logic [31:0] load_buf, load_buf_next;
  logic        is_load, is_store, is_mem;
  logic [1:0]  last_k;
  logic [31:0] load_ext;
  logic        unused_stall;

  assign unused_stall = ^{stall[5], stall[3:0]};

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    last_k   = 2'd0;
    case (mem_op_i)
      4'd1, 4'd4: is_load = 1'b1;
      4'd2, 4'd5: begin is_load = 1'b1; last_k = 2'd1; end
      4'd3:       begin is_load = 1'b1; last_k = 2'd3; end
      4'd6:       is_store = 1'b1;
      4'd7:       begin is_store = 1'b1; last_k = 2'd1; end
      4'd8:       begin is_store = 1'b1; last_k = 2'd3; end
      default:    ;
    endcase
    is_mem = is_load | is_store;
  end

  always_comb begin
    case (mem_op_i)
      4'd1:    load_ext = {{24{load_buf[7]}}, load_buf[7:0]};
      4'd2:    load_ext = {{16{load_buf[15]}}, load_buf[15:0]};
      4'd4:    load_ext = {24'd0, load_buf[7:0]};
      4'd5:    load_ext = {16'd0, load_buf[15:0]};
      default: load_ext = load_buf;
    endcase
  end

`ifdef MEM_MISALIGN_CHECK_EN
  logic misaligned, mis_q, mis_next;
  assign misaligned = ((last_k == 2'd1) && mem_addr_i[0]) ||
                      ((last_k == 2'd3) && (mem_addr_i[1:0] != 2'b00));
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      k        <= 2'd0;
      load_buf <= 32'd0;
`ifdef MEM_MISALIGN_CHECK_EN
      mis_q    <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      k        <= k_next;
      load_buf <= load_buf_next;
`ifdef MEM_MISALIGN_CHECK_EN
      mis_q    <= mis_next;
`endif
    end
  end

  always_comb begin
    state_next    = state;
    k_next        = k;
    load_buf_next = load_buf;
`ifdef MEM_MISALIGN_CHECK_EN
    mis_next      = mis_q;
`endif
    case (state)
      IDLE: begin
        if (is_mem) begin
          k_next        = 2'd0;
          load_buf_next = 32'd0;
`ifdef MEM_MISALIGN_CHECK_EN
          mis_next      = misaligned;
          state_next    = misaligned ? DONE : BUSY;
`else
          state_next    = BUSY;
`endif
        end
      end
      BUSY: begin
        if (mem_bus.mem_ack_i) begin
          if (is_load) load_buf_next[{k, 3'b000} +: 8] = mem_bus.mem_rbyte_i;
          if (k == last_k) begin
            state_next = DONE;
            k_next     = 2'd0;
          end else begin
            k_next = k + 2'd1;
          end
        end
      end
      DONE: begin
        // MEM/WB has captured the result; upstream will present the next instruction.
        if (!stall[4]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    write_o             = 1'b0;
    regw_addr_o         = 5'd0;
    regw_data_o         = 32'd0;
    stall_req_o         = 1'b0;
    misalign_o          = 1'b0;
    mem_bus.mem_req_o   = 1'b0;
    mem_bus.mem_we_o    = 1'b0;
    mem_bus.mem_addr_o  = '0;
    mem_bus.mem_wbyte_o = 8'd0;
    case (state)
      IDLE: begin
        regw_addr_o = regw_addr_i;
        if (is_mem) begin
          stall_req_o = 1'b1;
        end else begin
          write_o     = write_i;
          regw_data_o = regw_data_i;
        end
      end
      BUSY: begin
        regw_addr_o         = regw_addr_i;
        stall_req_o         = 1'b1;
        mem_bus.mem_req_o   = 1'b1;
        mem_bus.mem_we_o    = is_store;
        mem_bus.mem_addr_o  = mem_addr_i + ADDR_W'(k);
        mem_bus.mem_wbyte_o = mem_wdata_i[{k, 3'b000} +: 8];
      end
      DONE: begin
        regw_addr_o = regw_addr_i;
        if (is_load) begin
          write_o     = write_i;
          regw_data_o = load_ext;
        end
`ifdef MEM_MISALIGN_CHECK_EN
        if (mis_q) begin
          write_o     = 1'b0;
          regw_data_o = 32'd0;
          misalign_o  = 1'b1;
        end
`endif
      end
      default: ;
    endcase
    // Keep MEM/WB inputs quiet while reset is held so nothing stale is captured.
    if (!reset) begin
      write_o     = 1'b0;
      regw_addr_o = 5'd0;
      regw_data_o = 32'd0;
      stall_req_o = 1'b0;
      misalign_o  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus queues expected bus bytes and MEM/WB results,
// a monitor pops them as the DUT presents requests/results. Honours MEM_MISALIGN_CHECK_EN.
module tb_mem_stage;
  localparam int ADDR_W = 32;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  wbyte;
  } bus_exp_t;

  typedef struct {
    logic        write;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        chk_data;
    logic        mis;
  } wb_exp_t;

  logic              clock;
  logic              reset;
  logic [5:0]        stall;
  logic              write_i;
  logic [4:0]        regw_addr_i;
  logic [31:0]       regw_data_i;
  logic [3:0]        mem_op_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [31:0]       mem_wdata_i;
  logic              write_o;
  logic [4:0]        regw_addr_o;
  logic [31:0]       regw_data_o;
  logic              stall_req_o;
  logic              misalign_o;

  mem_stage_if #(.ADDR_W(ADDR_W)) bus ();

  mem_stage #(.ADDR_W(ADDR_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .stall       (stall),
    .write_i     (write_i),
    .regw_addr_i (regw_addr_i),
    .regw_data_i (regw_data_i),
    .mem_op_i    (mem_op_i),
    .mem_addr_i  (mem_addr_i),
    .mem_wdata_i (mem_wdata_i),
    .write_o     (write_o),
    .regw_addr_o (regw_addr_o),
    .regw_data_o (regw_data_o),
    .stall_req_o (stall_req_o),
    .misalign_o  (misalign_o),
    .mem_bus     (bus)
  );

  bus_exp_t   bus_q[$];
  wb_exp_t    wb_q[$];
  logic [7:0] mem_model [0:1023];
  int         ack_delay;
  int         wait_cnt;
  int         checks;
  int         errors;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushBus(input logic we, input logic [31:0] addr, input logic [7:0] wbyte);
    bus_exp_t e;
    e.we = we; e.addr = addr; e.wbyte = wbyte;
    bus_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after MEM/WB captured the result.
  task automatic applyStimulus(input logic [3:0] op, input logic wr, input logic [4:0] rd,
                               input logic [31:0] data, input logic [31:0] addr,
                               input logic [31:0] wdata, input int ackDelay, input int holdCycles,
                               input int expStall, input logic expWrite, input logic [31:0] expData,
                               input logic chkData, input logic expMis);
    wb_exp_t e;
    int stalled = 0;
    int held = 0;
    bit done = 0;
    mem_op_i = op; write_i = wr; regw_addr_i = rd; regw_data_i = data;
    mem_addr_i = addr; mem_wdata_i = wdata; ack_delay = ackDelay;
    stall = (holdCycles > 0) ? 6'b010000 : 6'b000000;
    e.write = expWrite; e.rd = rd; e.data = expData; e.chk_data = chkData; e.mis = expMis;
    wb_q.push_back(e);
    for (int c = 0; c < 80 && !done; c++) begin
      @(negedge clock);
      if (stall_req_o) stalled++;
      else if (held < holdCycles) begin
        held++;
        if (chkData) checkOutput("done_hold_data", regw_data_o, expData);
        if (held == holdCycles) begin
          @(posedge clock);
          #1 stall = 6'b000000;
        end
      end else done = 1;
    end
    if (!done) begin
      checks++; errors++;
      $display("[TB] FAIL instr_timeout: got no completion expected completion op=%0d", op);
    end
    checkOutput("stall_cycles", stalled, expStall);
    @(posedge clock);
    #1;
  endtask

  // Memory controller model: acks each requested byte after ack_delay idle cycles.
  initial begin
    bus.mem_ack_i   = 1'b0;
    bus.mem_rbyte_i = 8'h00;
    wait_cnt = 0;
    forever begin
      @(posedge clock);
      #2;
      if (bus.mem_req_o) begin
        if (wait_cnt == ack_delay) begin
          bus.mem_ack_i   = 1'b1;
          bus.mem_rbyte_i = mem_model[bus.mem_addr_o[9:0]];
          wait_cnt = 0;
        end else begin
          bus.mem_ack_i   = 1'b0;
          bus.mem_rbyte_i = 8'h00;
          wait_cnt++;
        end
      end else begin
        bus.mem_ack_i = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Monitor: bus bytes on ack, held request while ack is low, results when MEM/WB captures.
  initial begin
    bus_exp_t b;
    wb_exp_t  w;
    forever begin
      @(negedge clock);
      if (reset) begin
        if (bus.mem_req_o) begin
          if (bus_q.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL unexpected_bus_req: got addr 0x%0h expected no request", bus.mem_addr_o);
          end else if (bus.mem_ack_i) begin
            b = bus_q.pop_front();
            checkOutput("bus_we", bus.mem_we_o, b.we);
            checkOutput("bus_addr", bus.mem_addr_o, b.addr);
            checkOutput("bus_wbyte", bus.mem_wbyte_o, b.wbyte);
          end else begin
            checkOutput("bus_hold_addr", bus.mem_addr_o, bus_q[0].addr);
            checkOutput("bus_hold_we", bus.mem_we_o, bus_q[0].we);
          end
        end
        if (!stall_req_o && !stall[4]) begin
          if (wb_q.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL unexpected_wb: got data 0x%0h expected no result", regw_data_o);
          end else begin
            w = wb_q.pop_front();
            checkOutput("wb_write", write_o, w.write);
            checkOutput("wb_rd", regw_addr_o, w.rd);
            if (w.chk_data) checkOutput("wb_data", regw_data_o, w.data);
            checkOutput("wb_misalign", misalign_o, w.mis);
          end
        end
      end
    end
  end

  initial begin
    bit found;
    checks = 0; errors = 0; ack_delay = 0;
    for (int i = 0; i < 1024; i++) mem_model[i] = 8'h00;
    mem_model[10'h100] = 8'h78; mem_model[10'h101] = 8'h56;
    mem_model[10'h102] = 8'h34; mem_model[10'h103] = 8'h12;
    mem_model[10'h104] = 8'hEF; mem_model[10'h105] = 8'hBE;
    mem_model[10'h007] = 8'h80;
    mem_model[10'h200] = 8'h11; mem_model[10'h201] = 8'h22;
    mem_model[10'h202] = 8'h33; mem_model[10'h203] = 8'hC4;

    reset = 1'b0; stall = 6'd0; write_i = 1'b1; regw_addr_i = 5'd3; regw_data_i = 32'hDEAD;
    mem_op_i = 4'd0; mem_addr_i = '0; mem_wdata_i = 32'd0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_write_o", write_o, 1'b0);
    checkOutput("rst_regw_data_o", regw_data_o, 32'd0);
    checkOutput("rst_stall_req_o", stall_req_o, 1'b0);
    checkOutput("rst_mem_req_o", bus.mem_req_o, 1'b0);
    checkOutput("rst_misalign_o", misalign_o, 1'b0);
    @(posedge clock);
    #1 reset = 1'b1;

    $display("[TB] pass-through");
    applyStimulus(4'd0, 1'b1, 5'd5, 32'h1234, 32'h0, 32'h0, 0, 0, 0, 1'b1, 32'h1234, 1'b1, 1'b0);
    applyStimulus(4'd12, 1'b0, 5'd9, 32'hCAFEF00D, 32'h0, 32'h0, 0, 0, 0, 1'b0, 32'hCAFEF00D, 1'b1, 1'b0);

    $display("[TB] loads");
    for (int i = 0; i < 4; i++) pushBus(1'b0, 32'h100 + i, 8'h00);
    applyStimulus(4'd3, 1'b1, 5'd1, 32'h0, 32'h100, 32'h0, 0, 0, 5, 1'b1, 32'h12345678, 1'b1, 1'b0);
    pushBus(1'b0, 32'h7, 8'h00);
    applyStimulus(4'd1, 1'b1, 5'd2, 32'h0, 32'h7, 32'h0, 0, 0, 2, 1'b1, 32'hFFFFFF80, 1'b1, 1'b0);
    pushBus(1'b0, 32'h7, 8'h00);
    applyStimulus(4'd4, 1'b1, 5'd2, 32'h0, 32'h7, 32'h0, 0, 2, 2, 1'b1, 32'h00000080, 1'b1, 1'b0);
    pushBus(1'b0, 32'h202, 8'h00); pushBus(1'b0, 32'h203, 8'h00);
    applyStimulus(4'd2, 1'b1, 5'd4, 32'h0, 32'h202, 32'h0, 1, 0, 5, 1'b1, 32'hFFFFC433, 1'b1, 1'b0);
    pushBus(1'b0, 32'h202, 8'h00); pushBus(1'b0, 32'h203, 8'h00);
    applyStimulus(4'd5, 1'b1, 5'd4, 32'h0, 32'h202, 32'h0, 0, 0, 3, 1'b1, 32'h0000C433, 1'b1, 1'b0);

    $display("[TB] stores");
    pushBus(1'b1, 32'h20, 8'hDD); pushBus(1'b1, 32'h21, 8'hCC);
    applyStimulus(4'd7, 1'b1, 5'd0, 32'h0, 32'h20, 32'hAABBCCDD, 2, 0, 7, 1'b0, 32'h0, 1'b0, 1'b0);
    pushBus(1'b1, 32'h30, 8'h99);
    applyStimulus(4'd6, 1'b0, 5'd0, 32'h0, 32'h30, 32'h12345699, 0, 0, 2, 1'b0, 32'h0, 1'b0, 1'b0);

    $display("[TB] reset mid-access");
    pushBus(1'b0, 32'h200, 8'h00); pushBus(1'b0, 32'h201, 8'h00);
    mem_op_i = 4'd3; write_i = 1'b1; regw_addr_i = 5'd7; mem_addr_i = 32'h200;
    mem_wdata_i = 32'd0; stall = 6'd0; ack_delay = 3;
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clock);
      if (bus.mem_req_o && bus.mem_addr_o == 32'h201) found = 1;
    end
    if (!found) begin
      checks++; errors++;
      $display("[TB] FAIL reset_setup: got no second byte expected request at 0x201");
    end
    @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    checkOutput("midrst_mem_req_o", bus.mem_req_o, 1'b0);
    checkOutput("midrst_stall_req_o", stall_req_o, 1'b0);
    checkOutput("midrst_write_o", write_o, 1'b0);
    @(posedge clock);
    #1 reset = 1'b1;
    bus_q.delete();
    for (int i = 0; i < 4; i++) pushBus(1'b0, 32'h200 + i, 8'h00);
    applyStimulus(4'd3, 1'b1, 5'd7, 32'h0, 32'h200, 32'h0, 0, 0, 5, 1'b1, 32'hC4332211, 1'b1, 1'b0);

    $display("[TB] misaligned word");
`ifdef MEM_MISALIGN_CHECK_EN
    applyStimulus(4'd3, 1'b1, 5'd8, 32'h0, 32'h102, 32'h0, 0, 0, 1, 1'b0, 32'h0, 1'b1, 1'b1);
`else
    for (int i = 0; i < 4; i++) pushBus(1'b0, 32'h102 + i, 8'h00);
    applyStimulus(4'd3, 1'b1, 5'd8, 32'h0, 32'h102, 32'h0, 0, 0, 5, 1'b1, 32'hBEEF1234, 1'b1, 1'b0);
    pushBus(1'b1, 32'hFFFFFFFF, 8'hEF); pushBus(1'b1, 32'h0, 8'hBE);
    applyStimulus(4'd7, 1'b0, 5'd0, 32'h0, 32'hFFFFFFFF, 32'h0000BEEF, 0, 0, 3, 1'b0, 32'h0, 1'b0, 1'b0);
`endif

    checkOutput("bus_q_drained", bus_q.size(), 32'd0);
    checkOutput("wb_q_drained", wb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
